// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional
// parity bit, one stop bit. Internal baud-tick and bit counters; the host
// sees a start/busy/done handshake. All outputs are registered.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line high, waiting for tx_start; data and parity captured here
// START  | start bit (low) for one bit period
// DATA   | data bits, LSB first, shifted out of shreg_q
// PARITY | parity bit for one bit period (only when PARITY_EN = 1)
// STOP   | stop bit (high); leaving it pulses tx_done in the next IDLE cycle
module uart_tx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic          ODD      = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   parity_q, parity_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   tick;

    assign tick    = (cnt_q == CNT_MAX);
    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

    // Next-state, counters, shift register and registered-output decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        parity_d = parity_q;

        if (state_q != IDLE) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    shreg_d  = tx_data;
                    parity_d = (^tx_data) ^ ODD;
                    bit_d    = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (tick) state_d = DATA;
            end
            DATA: begin
                if (tick) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) state_d = STOP;
            end
            STOP: begin
                if (tick) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they change on the
        // same edge as the state register and never glitch.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_q == STOP) && tick;
    end

    // State, counters, data and output registers with async abort on reset
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: three instances (even parity, odd parity, no
// parity) at CLKS_PER_BIT = 4. Expected frames are built from the driven
// byte and queued; each frame is popped and checked cycle by cycle.
module tb_uart_tx;

    localparam int CPB = 4;

    typedef struct {
        logic [15:0] bits;
        int          n;
    } frame_t;

    logic       clk;
    logic       nrst;
    logic [2:0] start;
    logic [7:0] tx_data;
    logic [2:0] tx_w, busy_w, done_w;
    logic [1:0] sel;
    logic       tx_mon, busy_mon, done_mon;

    int tests;
    int fails;
    frame_t sb[$];

    uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
        .clk(clk), .nrst(nrst), .tx_start(start[0]), .tx_data(tx_data),
        .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));

    uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
        .clk(clk), .nrst(nrst), .tx_start(start[1]), .tx_data(tx_data),
        .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));

    uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_nopar (
        .clk(clk), .nrst(nrst), .tx_start(start[2]), .tx_data(tx_data),
        .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Select the instance under observation
    always_comb begin
        tx_mon   = 1'b1;
        busy_mon = 1'b0;
        done_mon = 1'b0;
        if (sel <= 2'd2) begin
            tx_mon   = tx_w[sel];
            busy_mon = busy_w[sel];
            done_mon = done_w[sel];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic frame_t build(input logic [7:0] d, input bit pe, input bit po);
        frame_t f;
        f.bits    = '0;
        f.bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) f.bits[1+i] = d[i];
        f.n = 9;
        if (pe) begin
            f.bits[9] = (^d) ^ po;
            f.n = 10;
        end
        f.bits[f.n] = 1'b1;
        f.n++;
        return f;
    endfunction

    task automatic send(input logic [1:0] s, input logic [7:0] d, input bit hold);
        sel      = s;
        tx_data  = d;
        start[s] = 1'b1;
        step();
        if (!hold) start[s] = 1'b0;
    endtask

    task automatic idle_chk(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_tx%0d", tag, i), tx_mon, 1);
            chk($sformatf("%s_busy%0d", tag, i), busy_mon, 0);
            chk($sformatf("%s_done%0d", tag, i), done_mon, 0);
            step();
        end
    endtask

    // Caller is positioned at the first start-bit sample; returns at the
    // tx_done sample without stepping past it.
    task automatic check_frame(input string tag, input int poke_at, input int clr_at);
        frame_t f;
        int     k;
        k = 0;
        chk({tag, "_sb_nonempty"}, (sb.size() > 0), 1);
        if (sb.size() == 0) return;
        f = sb.pop_front();
        for (int b = 0; b < f.n; b++) begin
            for (int c = 0; c < CPB; c++) begin
                if (k == poke_at) begin
                    start[sel] = 1'b1;
                    tx_data    = 8'h3C;
                end
                if (poke_at >= 0 && k == poke_at + 1) begin
                    start[sel] = 1'b0;
                    tx_data    = 8'hC3;
                end
                if (k == clr_at) start[sel] = 1'b0;
                chk($sformatf("%s_tx_b%0d_c%0d", tag, b, c), tx_mon, f.bits[b]);
                chk($sformatf("%s_busy_b%0d_c%0d", tag, b, c), busy_mon, 1);
                chk($sformatf("%s_done_b%0d_c%0d", tag, b, c), done_mon, 0);
                k++;
                step();
            end
        end
        chk({tag, "_done_pulse"}, done_mon, 1);
        chk({tag, "_done_busy"}, busy_mon, 0);
        chk({tag, "_done_tx"}, tx_mon, 1);
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        nrst    = 1'b0;
        start   = 3'b000;
        tx_data = 8'h00;
        sel     = 2'd0;

        // Reset values with tx_start held high
        step();
        start   = 3'b111;
        tx_data = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            for (int s = 0; s < 3; s++) begin
                chk($sformatf("rst_tx_u%0d_%0d", s, i), tx_w[s], 1);
                chk($sformatf("rst_busy_u%0d_%0d", s, i), busy_w[s], 0);
                chk($sformatf("rst_done_u%0d_%0d", s, i), done_w[s], 0);
            end
            step();
        end
        start = 3'b000;
        step();
        nrst = 1'b1;
        step();
        idle_chk("post_rst", 2);

        // Even-parity frame
        sb.push_back(build(8'hA5, 1'b1, 1'b0));
        send(2'd0, 8'hA5, 1'b0);
        check_frame("even_a5", -1, -1);
        step();
        idle_chk("even_a5_after", 3);

        // Odd parity
        sb.push_back(build(8'h07, 1'b1, 1'b1));
        send(2'd1, 8'h07, 1'b0);
        check_frame("odd_07", -1, -1);
        step();
        idle_chk("odd_07_after", 3);

        // No parity
        sb.push_back(build(8'h07, 1'b0, 1'b0));
        send(2'd2, 8'h07, 1'b0);
        check_frame("nopar_07", -1, -1);
        step();
        idle_chk("nopar_07_after", 3);

        // Busy protection and data change mid-frame
        sb.push_back(build(8'h55, 1'b1, 1'b0));
        send(2'd0, 8'h55, 1'b0);
        tx_data = 8'h00;
        check_frame("busy_55", 10, -1);
        step();
        idle_chk("busy_no_second", 12);

        // Back-to-back frames with tx_start held high
        sb.push_back(build(8'h00, 1'b1, 1'b0));
        sb.push_back(build(8'hFF, 1'b1, 1'b0));
        send(2'd0, 8'h00, 1'b1);
        tx_data = 8'hFF;
        check_frame("b2b_00", -1, -1);
        step();
        check_frame("b2b_ff", -1, 0);
        step();
        idle_chk("b2b_after", 4);

        // Reset during data bit 3, then a clean frame
        send(2'd0, 8'hF0, 1'b0);
        for (int i = 0; i < 17; i++) step();
        chk("abort_pre_tx", tx_mon, 0);
        chk("abort_pre_busy", busy_mon, 1);
        nrst = 1'b0;
        #1;
        chk("abort_tx_now", tx_mon, 1);
        chk("abort_busy_now", busy_mon, 0);
        chk("abort_done_now", done_mon, 0);
        step();
        idle_chk("abort_in_rst", 3);
        nrst = 1'b1;
        step();
        idle_chk("abort_released", 50);

        sb.push_back(build(8'h81, 1'b1, 1'b0));
        send(2'd0, 8'h81, 1'b0);
        check_frame("after_abort_81", -1, -1);
        step();
        idle_chk("after_abort_idle", 2);

        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
